// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle RV32M multiply/divide controller (shift-add multiply,
//            restoring divide), one iteration per cycle, pipeline stall.
//            Define MULDIV_SIGNED_EN to support the signed funct3 codes.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int         c_CNT_W   = $clog2(XLEN);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state_q,   w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [2*XLEN-1:0] r_acc_q,     w_acc_d;
    logic [XLEN-1:0]   r_opb_q,     w_opb_d;
    logic              r_is_div_q,  w_is_div_d;
    logic              r_hi_q,      w_hi_d;
    logic [XLEN-1:0]   r_result_q,  w_result_d;
    logic              r_done_q,    w_done_d;
    logic              r_illegal_q, w_illegal_d;

    logic              w_supported;
    logic [XLEN-1:0]   w_a_in;
    logic [XLEN-1:0]   w_b_in;
    logic [XLEN-1:0]   w_res_fin;

    // One iteration step; the accumulator holds {hi, lo} for both operations
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_acc_n;
    logic [XLEN-1:0]   w_sel_raw;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc_q[2*XLEN-1:XLEN]}
                    + (r_acc_q[0] ? {1'b0, r_opb_q} : {(XLEN+1){1'b0}});
        w_div_trial = {r_acc_q[2*XLEN-1:XLEN], r_acc_q[XLEN-1]} - {1'b0, r_opb_q};
        if (!r_is_div_q)
            w_acc_n = {w_mul_sum, r_acc_q[XLEN-1:1]};
        else if (w_div_trial[XLEN])
            w_acc_n = {r_acc_q[2*XLEN-2:XLEN], r_acc_q[XLEN-1:0], 1'b0};
        else
            w_acc_n = {w_div_trial[XLEN-1:0], r_acc_q[XLEN-2:0], 1'b1};
        w_sel_raw = r_hi_q ? w_acc_n[2*XLEN-1:XLEN] : w_acc_n[XLEN-1:0];
    end

`ifdef MULDIV_SIGNED_EN
    logic              r_neg_q, w_neg_d;
    logic              w_a_neg, w_b_neg, w_neg_start;
    logic [2*XLEN-1:0] w_prod_fin;

    always_comb begin
        w_supported = 1'b1;
        w_a_neg = op_a[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b010) |
                                  (func3 == 3'b100) | (func3 == 3'b110));
        w_b_neg = op_b[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b100) |
                                  (func3 == 3'b110));
        w_a_in  = w_a_neg ? -op_a : op_a;
        w_b_in  = w_b_neg ? -op_b : op_b;
        case (func3)
            3'b001, 3'b010: w_neg_start = w_a_neg ^ w_b_neg;
            3'b100:         w_neg_start = (w_a_neg ^ w_b_neg) & (|op_b);
            3'b110:         w_neg_start = w_a_neg;
            default:        w_neg_start = 1'b0;
        endcase
        // Products are negated over the full width before picking a word
        w_prod_fin = r_neg_q ? -w_acc_n : w_acc_n;
        if (r_is_div_q)
            w_res_fin = r_neg_q ? -w_sel_raw : w_sel_raw;
        else
            w_res_fin = r_hi_q ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0];
    end
`else
    always_comb begin
        w_supported = (func3 == 3'b000) | (func3 == 3'b101) | (func3[1:0] == 2'b11);
        w_a_in      = op_a;
        w_b_in      = op_b;
        w_res_fin   = w_sel_raw;
    end
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_acc_d     = r_acc_q;
        w_opb_d     = r_opb_q;
        w_is_div_d  = r_is_div_q;
        w_hi_d      = r_hi_q;
        w_result_d  = r_result_q;
        w_done_d    = 1'b0;
        w_illegal_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        w_neg_d     = r_neg_q;
`endif
        case (r_state_q)
            c_ST_IDLE: begin
                if (start && !flush) begin
                    if (w_supported) begin
                        w_state_d  = c_ST_RUN;
                        w_cnt_d    = '0;
                        w_acc_d    = {{XLEN{1'b0}}, w_a_in};
                        w_opb_d    = w_b_in;
                        w_is_div_d = func3[2];
                        w_hi_d     = func3[2] ? func3[1] : (func3[1:0] != 2'b00);
`ifdef MULDIV_SIGNED_EN
                        w_neg_d    = w_neg_start;
`endif
                    end else begin
                        w_state_d   = c_ST_DONE;
                        w_result_d  = '0;
                        w_done_d    = 1'b1;
                        w_illegal_d = 1'b1;
                    end
                end
            end
            c_ST_RUN: begin
                if (flush) begin
                    w_state_d = c_ST_IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_acc_d = w_acc_n;
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                    if (r_cnt_q == c_CNT_W'(XLEN-1)) begin
                        w_state_d  = c_ST_DONE;
                        w_cnt_d    = '0;
                        w_result_d = w_res_fin;
                        w_done_d   = 1'b1;
                    end
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_ST_IDLE;
            r_cnt_q     <= '0;
            r_acc_q     <= '0;
            r_opb_q     <= '0;
            r_is_div_q  <= 1'b0;
            r_hi_q      <= 1'b0;
            r_result_q  <= '0;
            r_done_q    <= 1'b0;
            r_illegal_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q     <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_acc_q     <= w_acc_d;
            r_opb_q     <= w_opb_d;
            r_is_div_q  <= w_is_div_d;
            r_hi_q      <= w_hi_d;
            r_result_q  <= w_result_d;
            r_done_q    <= w_done_d;
            r_illegal_q <= w_illegal_d;
`ifdef MULDIV_SIGNED_EN
            r_neg_q     <= w_neg_d;
`endif
        end
    end

    assign stall   = ((r_state_q == c_ST_IDLE) & start) | (r_state_q == c_ST_RUN);
    assign busy    = (r_state_q != c_ST_IDLE);
    assign done    = r_done_q;
    assign result  = r_result_q;
    assign illegal = r_illegal_q;

endmodule
`default_nettype wire
